// File: rtl/timer_responder.sv
// Memory-mapped timer responder: prescaled 32-bit tick counter with COUNT/CTRL registers.
// Define TIMER_IRQ_EN to add the registered wrap-interrupt pending flag.
module timer_responder #(
  parameter logic [30:0] DIV_RESET   = 31'd99_999,
  parameter logic [31:0] COUNT_RESET = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [31:0] count_q, count_d;
  logic [30:0] div_q, div_d;
  logic [30:0] pre_q, pre_d;
  logic        tick;
  logic        wr_count;
  logic        wr_ctrl;
  logic        irq_pend;

  assign tick     = (pre_q == div_q);
  assign wr_count = we & ~addr[2];
  assign wr_ctrl  = we & addr[2];

  // A COUNT write overrides the tick; a CTRL write still lets the old tick increment.
  always_comb begin
    count_d = count_q;
    div_d   = div_q;
    pre_d   = pre_q + 31'd1;
    if (tick) begin
      pre_d   = '0;
      count_d = count_q + 32'd1;
    end
    if (wr_count) begin
      count_d = wdata;
      pre_d   = '0;
    end
    if (wr_ctrl) begin
      div_d = wdata[30:0];
      pre_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= COUNT_RESET;
      div_q   <= DIV_RESET;
      pre_q   <= '0;
    end else begin
      count_q <= count_d;
      div_q   <= div_d;
      pre_q   <= pre_d;
    end
  end

`ifdef TIMER_IRQ_EN
  logic irq_pend_q, irq_pend_d;
  logic irq_set, irq_clr;

  // Set on wrap unless a COUNT write replaces the wrapped value; set wins over clear.
  assign irq_set = tick & (count_q == 32'hFFFF_FFFF) & ~wr_count;
  assign irq_clr = wr_ctrl & wdata[31];

  always_comb begin
    irq_pend_d = irq_pend_q;
    if (irq_clr) irq_pend_d = 1'b0;
    if (irq_set) irq_pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_pend_q <= 1'b0;
    end else begin
      irq_pend_q <= irq_pend_d;
    end
  end

  assign irq_pend = irq_pend_q;
`else
  logic unused_wdata;
  assign unused_wdata = wdata[31];
  assign irq_pend     = 1'b0;
`endif

  // Only addr[2] selects; the bridge has already decoded the window.
  logic unused_addr;
  assign unused_addr = ^{addr[31:3], addr[1:0]};

  always_comb begin
    rdata = addr[2] ? {irq_pend, div_q} : count_q;
  end

  assign irq = irq_pend;

endmodule
